// File: rtl/orbit_position_calc.sv
// Per-frame planet orbit position calculator: folds each angle onto a quarter-wave
// sine table and publishes all six screen coordinates together with a one-cycle strobe.
//
// state   | meaning
// IDLE    | waiting for frame_start; outputs hold last published frame
// FOLD    | derive table index and sign for job k
// LOOK    | registered sine table read
// MAC     | scale by radius, apply sign, offset from centre into shadow reg
// PUBLISH | copy shadow regs to outputs, strobe pos_valid
module orbit_position_calc #(
  parameter int CX       = 960,
  parameter int CY       = 540,
  parameter int R_MERCUR = 120,
  parameter int R_VENUS  = 220,
  parameter int R_EARTH  = 320
) (
  input  logic        clk1485,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [8:0]  angle_mercur,
  input  logic [8:0]  angle_venus,
  input  logic [8:0]  angle_earth,
  output logic [10:0] x_mercur,
  output logic [10:0] y_mercur,
  output logic [10:0] x_venus,
  output logic [10:0] y_venus,
  output logic [10:0] x_earth,
  output logic [10:0] y_earth,
  output logic        pos_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, FOLD, LOOK, MAC, PUBLISH} state_t;

  localparam logic [10:0] CX_L = 11'(CX);
  localparam logic [10:0] CY_L = 11'(CY);
  localparam logic [8:0]  R_M  = 9'(R_MERCUR);
  localparam logic [8:0]  R_V  = 9'(R_VENUS);
  localparam logic [8:0]  R_E  = 9'(R_EARTH);

  function automatic logic [8:0] sanitise(input logic [8:0] a);
    return (a >= 9'd360) ? a - 9'd360 : a;
  endfunction

  // round(256*sin(d)) for d = 0..90
  function automatic logic [8:0] sine_lut(input logic [6:0] d);
    logic [8:0] s;
    case (d)
      7'd0:  s = 9'd0;   7'd1:  s = 9'd4;   7'd2:  s = 9'd9;   7'd3:  s = 9'd13;
      7'd4:  s = 9'd18;  7'd5:  s = 9'd22;  7'd6:  s = 9'd27;  7'd7:  s = 9'd31;
      7'd8:  s = 9'd36;  7'd9:  s = 9'd40;  7'd10: s = 9'd44;  7'd11: s = 9'd49;
      7'd12: s = 9'd53;  7'd13: s = 9'd58;  7'd14: s = 9'd62;  7'd15: s = 9'd66;
      7'd16: s = 9'd71;  7'd17: s = 9'd75;  7'd18: s = 9'd79;  7'd19: s = 9'd83;
      7'd20: s = 9'd88;  7'd21: s = 9'd92;  7'd22: s = 9'd96;  7'd23: s = 9'd100;
      7'd24: s = 9'd104; 7'd25: s = 9'd108; 7'd26: s = 9'd112; 7'd27: s = 9'd116;
      7'd28: s = 9'd120; 7'd29: s = 9'd124; 7'd30: s = 9'd128; 7'd31: s = 9'd132;
      7'd32: s = 9'd136; 7'd33: s = 9'd139; 7'd34: s = 9'd143; 7'd35: s = 9'd147;
      7'd36: s = 9'd150; 7'd37: s = 9'd154; 7'd38: s = 9'd158; 7'd39: s = 9'd161;
      7'd40: s = 9'd165; 7'd41: s = 9'd168; 7'd42: s = 9'd171; 7'd43: s = 9'd175;
      7'd44: s = 9'd178; 7'd45: s = 9'd181; 7'd46: s = 9'd184; 7'd47: s = 9'd187;
      7'd48: s = 9'd190; 7'd49: s = 9'd193; 7'd50: s = 9'd196; 7'd51: s = 9'd199;
      7'd52: s = 9'd202; 7'd53: s = 9'd204; 7'd54: s = 9'd207; 7'd55: s = 9'd210;
      7'd56: s = 9'd212; 7'd57: s = 9'd215; 7'd58: s = 9'd217; 7'd59: s = 9'd219;
      7'd60: s = 9'd222; 7'd61: s = 9'd224; 7'd62: s = 9'd226; 7'd63: s = 9'd228;
      7'd64: s = 9'd230; 7'd65: s = 9'd232; 7'd66: s = 9'd234; 7'd67: s = 9'd236;
      7'd68: s = 9'd237; 7'd69: s = 9'd239; 7'd70: s = 9'd241; 7'd71: s = 9'd242;
      7'd72: s = 9'd243; 7'd73: s = 9'd245; 7'd74: s = 9'd246; 7'd75: s = 9'd247;
      7'd76: s = 9'd248; 7'd77: s = 9'd249; 7'd78: s = 9'd250; 7'd79: s = 9'd251;
      7'd80: s = 9'd252; 7'd81: s = 9'd253; 7'd82: s = 9'd254; 7'd83: s = 9'd254;
      7'd84: s = 9'd255; 7'd85: s = 9'd255; 7'd86: s = 9'd255; 7'd87: s = 9'd256;
      7'd88: s = 9'd256; 7'd89: s = 9'd256; 7'd90: s = 9'd256;
      default: s = 9'd0;
    endcase
    return s;
  endfunction

  state_t      state;
  logic [2:0]  k;
  logic [8:0]  ang_m, ang_v, ang_e;
  logic [6:0]  idx;
  logic        neg;
  logic [8:0]  s_val;
  logic [10:0] sh_xm, sh_ym, sh_xv, sh_yv, sh_xe, sh_ye;

  logic [8:0]  job_ang;
  logic [9:0]  eff_ang;
  logic [6:0]  f_idx;
  logic        f_neg;
  logic [8:0]  r_sel;
  logic [17:0] prod;
  logic [9:0]  mag;
  logic [10:0] centre;
  logic [10:0] coord;

  // Odd jobs are cosines: shift the angle by 90 degrees before folding.
  always_comb begin
    case (k[2:1])
      2'd0:    begin job_ang = ang_m; r_sel = R_M; end
      2'd1:    begin job_ang = ang_v; r_sel = R_V; end
      default: begin job_ang = ang_e; r_sel = R_E; end
    endcase
    eff_ang = {1'b0, job_ang};
    if (k[0]) begin
      eff_ang = {1'b0, job_ang} + 10'd90;
      if (eff_ang >= 10'd360) eff_ang = eff_ang - 10'd360;
    end
    if (eff_ang < 10'd90) begin
      f_idx = eff_ang[6:0];
      f_neg = 1'b0;
    end else if (eff_ang < 10'd180) begin
      f_idx = 7'(10'd180 - eff_ang);
      f_neg = 1'b0;
    end else if (eff_ang < 10'd270) begin
      f_idx = 7'(eff_ang - 10'd180);
      f_neg = 1'b1;
    end else begin
      f_idx = 7'(10'd360 - eff_ang);
      f_neg = 1'b1;
    end
  end

  // Sign is applied after truncation so offsets stay symmetric about the centre.
  // Screen y grows downward, so a positive sine subtracts from CY.
  always_comb begin
    prod   = 18'(r_sel) * 18'(s_val);
    mag    = 10'(prod >> 8);
    centre = k[0] ? CX_L : CY_L;
    coord  = (k[0] ^ neg) ? centre + 11'(mag) : centre - 11'(mag);
  end

  always_ff @(posedge clk1485) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 3'd0;
      busy      <= 1'b0;
      pos_valid <= 1'b0;
      ang_m     <= 9'd0;
      ang_v     <= 9'd0;
      ang_e     <= 9'd0;
      idx       <= 7'd0;
      neg       <= 1'b0;
      s_val     <= 9'd0;
      sh_xm <= CX_L; sh_ym <= CY_L;
      sh_xv <= CX_L; sh_yv <= CY_L;
      sh_xe <= CX_L; sh_ye <= CY_L;
      x_mercur <= CX_L; y_mercur <= CY_L;
      x_venus  <= CX_L; y_venus  <= CY_L;
      x_earth  <= CX_L; y_earth  <= CY_L;
    end else begin
      pos_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            ang_m <= sanitise(angle_mercur);
            ang_v <= sanitise(angle_venus);
            ang_e <= sanitise(angle_earth);
            k     <= 3'd0;
            busy  <= 1'b1;
            state <= FOLD;
          end
        end
        FOLD: begin
          idx   <= f_idx;
          neg   <= f_neg;
          state <= LOOK;
        end
        LOOK: begin
          s_val <= sine_lut(idx);
          state <= MAC;
        end
        MAC: begin
          case (k)
            3'd0:    sh_ym <= coord;
            3'd1:    sh_xm <= coord;
            3'd2:    sh_yv <= coord;
            3'd3:    sh_xv <= coord;
            3'd4:    sh_ye <= coord;
            default: sh_xe <= coord;
          endcase
          if (k == 3'd5) begin
            state <= PUBLISH;
          end else begin
            k     <= k + 3'd1;
            state <= FOLD;
          end
        end
        PUBLISH: begin
          x_mercur  <= sh_xm; y_mercur <= sh_ym;
          x_venus   <= sh_xv; y_venus  <= sh_yv;
          x_earth   <= sh_xe; y_earth  <= sh_ye;
          pos_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
